// File: rtl/pdm_sequencer_pkg.sv
// Shared defaults and FSM state type for the PDM level sequencer.
package pdm_sequencer_pkg;

    localparam int unsigned LEVEL_W_DEF   = 5;
    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned FRAME_LEN_DEF = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHold  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pdm_frame_timer.sv
// Loadable down-counter that paces level writes; zero flags end of a frame.
module pdm_frame_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pdm_sequencer.sv
// Plays a table of PDM levels, one write strobe every FRAME_LEN clocks, optionally looping.
module pdm_sequencer
    import pdm_sequencer_pkg::*;
#(
    parameter int unsigned LEVEL_W   = LEVEL_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [LEVEL_W-1:0]       cfg_data,
    input  logic [$clog2(DEPTH)-1:0] cfg_last,
    input  logic                     cfg_loop,
    input  logic                     start,
    input  logic                     stop,
    output logic                     pdm_we,
    output logic [LEVEL_W-1:0]       pdm_level,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     done
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    seq_state_e         state_q;
    logic [AW-1:0]      last_q;
    logic               loop_q;
    logic [LEVEL_W-1:0] lvl_tab [DEPTH];
    logic               frame_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                lvl_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            lvl_tab[cfg_addr] <= cfg_data;
        end
    end

    // Hold spans FRAME_LEN-1 cycles so issue-to-issue spacing is exactly FRAME_LEN.
    pdm_frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state_q == StIssue),
        .load_val (CNT_W'(FRAME_LEN - 2)),
        .dec      (state_q == StHold),
        .zero     (frame_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            idx       <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            pdm_we    <= 1'b0;
            pdm_level <= '0;
            done      <= 1'b0;
        end else begin
            pdm_we <= 1'b0;
            done   <= 1'b0;
            if (stop) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StIssue;
                            idx     <= '0;
                            last_q  <= cfg_last;
                            loop_q  <= cfg_loop;
                        end
                    end
                    StIssue: begin
                        // Table read lands at the same edge as any write, so the old value issues.
                        pdm_we    <= 1'b1;
                        pdm_level <= lvl_tab[idx];
                        state_q   <= StHold;
                    end
                    StHold: begin
                        if (frame_zero) begin
                            if (idx != last_q) begin
                                idx     <= idx + AW'(1);
                                state_q <= StIssue;
                            end else if (loop_q) begin
                                idx     <= '0;
                                state_q <= StIssue;
                            end else begin
                                done    <= 1'b1;
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_pdm_sequencer.sv
// Scoreboard bench: expected strobes and done pulses are queued per scenario and checked on negedge.
module tb_pdm_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic [2:0] cfg_last = '0;
    logic       cfg_loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pdm_we;
    logic [4:0] pdm_level;
    logic       busy;
    logic [2:0] idx;
    logic       done;

    pdm_sequencer #(
        .LEVEL_W   (5),
        .DEPTH     (8),
        .FRAME_LEN (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_loop  (cfg_loop),
        .start     (start),
        .stop      (stop),
        .pdm_we    (pdm_we),
        .pdm_level (pdm_level),
        .busy      (busy),
        .idx       (idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] lvl;
        logic [2:0] ix;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    wr_t e;
    int  dc;

    always @(negedge clk) begin
        if (pdm_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pdm_we cyc=%0d got level=%h required no strobe",
                         cyc, pdm_level);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || pdm_level !== e.lvl || idx !== e.ix) begin
                    miscompares++;
                    $display("FAIL pdm_we_event got cyc=%0d level=%h idx=%0d required cyc=%0d level=%h idx=%0d",
                             cyc, pdm_level, idx, e.cyc, e.lvl, e.ix);
                end
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done cyc=%0d got done=1 required 0", cyc);
            end else begin
                dc = done_q.pop_front();
                if (cyc !== dc) begin
                    miscompares++;
                    $display("FAIL done_cycle got cyc=%0d required cyc=%0d", cyc, dc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_we(input int c, input logic [4:0] l, input logic [2:0] i);
        wr_t w;
        w.cyc = c;
        w.lvl = l;
        w.ix  = i;
        exp_q.push_back(w);
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [4:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Returns the edge at which start is sampled; the bench is just past that edge on return.
    task automatic kick(input logic [2:0] last, input logic loop, output int t0);
        cfg_last = last;
        cfg_loop = loop;
        start    = 1'b1;
        t0       = cyc + 1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({pdm_we, pdm_level, done, idx, busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got we=%b lvl=%h done=%b idx=%0d busy=%b required all 0",
                     pdm_we, pdm_level, done, idx, busy);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_busy got %b required 0", busy);
        end
    endtask

    task automatic test_one_shot();
        int t0;
        write_entry(3'd0, 5'h08);
        write_entry(3'd1, 5'h1A);
        write_entry(3'd2, 5'h0F);
        write_entry(3'd3, 5'h04);
        kick(3'd3, 1'b0, t0);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1A, 3'd1);
        push_we(t0 + 129, 5'h0F, 3'd2);
        push_we(t0 + 193, 5'h04, 3'd3);
        done_q.push_back(t0 + 256);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL one_shot_busy got %b required 1", busy);
        end
        run_until(t0 + 100);
        vectors++;
        if (pdm_level !== 5'h1A) begin
            miscompares++;
            $display("FAIL one_shot_level_hold got %h required 1a", pdm_level);
        end
        run_until(t0 + 257);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL one_shot_end got busy=%b pending_we=%0d pending_done=%0d required 0/0/0",
                     busy, exp_q.size(), done_q.size());
        end
        run_until(t0 + 330);
    endtask

    task automatic test_loop();
        int t0;
        kick(3'd3, 1'b1, t0);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1A, 3'd1);
        push_we(t0 + 129, 5'h0F, 3'd2);
        push_we(t0 + 193, 5'h04, 3'd3);
        push_we(t0 + 257, 5'h08, 3'd0);
        run_until(t0 + 260);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until(t0 + 400);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL loop_end got busy=%b pending_we=%0d required 0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_stop();
        int t0;
        kick(3'd3, 1'b1, t0);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1A, 3'd1);
        run_until(t0 + 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_busy got %b required 0", busy);
        end
        run_until(t0 + 300);
        vectors++;
        if (pdm_level !== 5'h1A || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stop_level got level=%h pending_we=%0d required 1a/0",
                     pdm_level, exp_q.size());
        end
    endtask

    task automatic test_start_stop_idle();
        int t0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop_idle got busy=%b required 0", busy);
        end
        repeat (70) tick();
        kick(3'd1, 1'b0, t0);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1A, 3'd1);
        done_q.push_back(t0 + 128);
        run_until(t0 + 30);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(t0 + 200);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL start_while_busy got busy=%b pending_we=%0d pending_done=%0d required 0/0/0",
                     busy, exp_q.size(), done_q.size());
        end
    endtask

    task automatic test_cfg_write();
        int t0;
        kick(3'd1, 1'b0, t0);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1F, 3'd1);
        done_q.push_back(t0 + 128);
        run_until(t0 + 10);
        write_entry(3'd1, 5'h1F);
        cfg_last = 3'd7;
        cfg_loop = 1'b1;
        run_until(t0 + 200);
        // Second run: entry 0 rewritten during its own issue cycle.
        kick(3'd1, 1'b0, t0);
        write_entry(3'd0, 5'h15);
        push_we(t0 + 1, 5'h08, 3'd0);
        push_we(t0 + 65, 5'h1F, 3'd1);
        done_q.push_back(t0 + 128);
        run_until(t0 + 200);
        vectors++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL cfg_write_end got pending_we=%0d pending_done=%0d required 0/0",
                     exp_q.size(), done_q.size());
        end
    endtask

    task automatic test_last_zero();
        int t0;
        kick(3'd0, 1'b0, t0);
        push_we(t0 + 1, 5'h15, 3'd0);
        done_q.push_back(t0 + 64);
        run_until(t0 + 150);
        kick(3'd0, 1'b1, t0);
        push_we(t0 + 1, 5'h15, 3'd0);
        push_we(t0 + 65, 5'h15, 3'd0);
        push_we(t0 + 129, 5'h15, 3'd0);
        run_until(t0 + 130);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until(t0 + 250);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL last_zero_end got busy=%b pending_we=%0d pending_done=%0d required 0/0/0",
                     busy, exp_q.size(), done_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        kick(3'd3, 1'b1, t0);
        push_we(t0 + 1, 5'h15, 3'd0);
        run_until(t0 + 20);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pdm_we, pdm_level, done, idx, busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async got we=%b lvl=%h done=%b idx=%0d busy=%b required all 0",
                     pdm_we, pdm_level, done, idx, busy);
        end
        tick();
        tick();
        reset_n = 1'b1;
        repeat (100) tick();
        kick(3'd1, 1'b0, t0);
        push_we(t0 + 1, 5'h00, 3'd0);
        push_we(t0 + 65, 5'h00, 3'd1);
        done_q.push_back(t0 + 128);
        run_until(t0 + 200);
        vectors++;
        if (busy !== 1'b0 || exp_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_end got busy=%b pending_we=%0d pending_done=%0d required 0/0/0",
                     busy, exp_q.size(), done_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_loop();
        test_stop();
        test_start_stop_idle();
        test_cfg_write();
        test_last_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout required bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pdm_sequencer.md
PDM_SEQUENCER -- requirements
Module: pdm_sequencer

Interface
REQ-001 SHALL have parameter LEVEL_W, default 5, PDM level width.
REQ-002 SHALL have parameter DEPTH, default 8, level table entries (power of two).
REQ-003 SHALL have parameter FRAME_LEN, default 64, clocks between consecutive level writes (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_we  input  1  write table entry this cycle.
REQ-007 SHALL have port cfg_addr  input  log2(DEPTH)  table entry index.
REQ-008 SHALL have port cfg_data  input  LEVEL_W  level written to entry.
REQ-009 SHALL have port cfg_last  input  log2(DEPTH)  index of last entry to play, sampled at start.
REQ-010 SHALL have port cfg_loop  input  1  1 = wrap to entry 0 after last, sampled at start.
REQ-011 SHALL have port start  input  1  begin playback from entry 0.
REQ-012 SHALL have port stop  input  1  abort playback.
REQ-013 SHALL have port pdm_we  output  1  one-cycle write strobe to the PDM datapath.
REQ-014 SHALL have port pdm_level  output  LEVEL_W  level presented with pdm_we.
REQ-015 SHALL have port busy  output  1  playback active.
REQ-016 SHALL have port idx  output  log2(DEPTH)  entry currently playing.
REQ-017 SHALL have port done  output  1  one-cycle pulse on one-shot completion.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, HOLD; busy = (state != IDLE).
REQ-019 IDLE: start=1 and stop=0 -> ISSUE, idx<=0, latch cfg_last/cfg_loop; else stay.
REQ-020 ISSUE (1 cycle): pdm_we=1, pdm_level=table[idx]; -> HOLD, frame counter <= FRAME_LEN-2.
REQ-021 HOLD: counter decrements each cycle; at counter==0 and idx!=last -> idx+1, ISSUE.
REQ-022 HOLD at counter==0 and idx==last: loop=1 -> idx<=0, ISSUE; loop=0 -> done=1 for 1 cycle, IDLE.
REQ-023 Consecutive pdm_we pulses SHALL be exactly FRAME_LEN cycles apart, including across wrap.
REQ-024 First pdm_we SHALL occur the cycle after start is sampled in IDLE.
REQ-025 pdm_we, pdm_level, done, idx SHALL be registered outputs; pdm_level holds last issued value between strobes.
REQ-026 stop=1 in any state SHALL force IDLE next cycle, no pdm_we, no done; stop wins over simultaneous start.
REQ-027 start while busy SHALL be ignored.
REQ-028 cfg_we SHALL write table[cfg_addr] in any state; write and read of same entry in one ISSUE cycle issues the old value.
REQ-029 cfg_last/cfg_loop changes while busy SHALL have no effect until next start.
REQ-030 cfg_last=0 SHALL play entry 0 alone (repeatedly if loop).

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, pdm_we=0, pdm_level=0, done=0, idx=0, counter=0, latched cfg=0, all table entries 0.
REQ-032 Reset asserted mid-playback SHALL abort without a further pdm_we; playback resumes only on a new start.

Structure
REQ-033 Shared package SHALL hold LEVEL_W, DEPTH, FRAME_LEN defaults and the FSM state enum.
REQ-034 Frame counter SHALL be sub-module pdm_frame_timer (load, decrement, zero flag); table and FSM stay in pdm_sequencer.

Verification
REQ-035 Load {08,1A,0F,04} into entries 0-3, cfg_last=3, loop=0, start -> pdm_we at cycles 1,65,129,193 with levels 08,1A,0F,04; done at cycle 256; busy low after.
REQ-036 Same table, loop=1 -> fifth pdm_we at cycle 257 with level 08, idx=0; no done.
REQ-037 stop at cycle 100 of looping playback -> busy low cycle 101, no pdm_we after cycle 65, pdm_level stays 1A.
REQ-038 start and stop together in IDLE -> stays IDLE, no pdm_we; start at cycle 30 while busy -> pulse spacing unchanged.
REQ-039 cfg_we entry 1 = 1F during entry-0 HOLD -> second pdm_we level 1F; write entry 0 in ISSUE cycle -> old value issued.
REQ-040 reset_n low mid-HOLD (async, between edges) -> all outputs 0 immediately, table reads 0 on next start.
